traffic_phase_controller: RTL
=============================

Name: traffic_phase_controller

Overview:
- Parametrised N-phase traffic light controller; next generation of the fixed four-road Traffic_Light_Controller.
- Serves NUM_PHASES conflicting approaches one at a time: green -> yellow -> all-red.
- Adds demand-driven round-robin phase skipping, an external timebase strobe and emergency all-red preemption.
- Sits at the top of the intersection design, driving the lamp drivers directly.

Parameters:
- NUM_PHASES, 4: number of approaches; must be >= 2.
- CNT_W, 8: timer width; every duration must be <= 2**CNT_W.
- GREEN_T, 7: green duration in ticks; must be >= 1.
- YELLOW_T, 3: yellow duration in ticks; must be >= 1.
- ALLRED_T, 2: all-red clearance duration in ticks; must be >= 1.
- MAX_GREEN_T, 15: green ceiling when extension is compiled in; must be >= GREEN_T.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- tick_en  input  1  one-cycle timebase strobe; all timers advance only when high
- req  input  NUM_PHASES  per-phase vehicle demand, level-sensitive
- emerg  input  1  emergency preemption request, level-sensitive
- lights  output  3*NUM_PHASES  lamp code of phase i at bits [3i+2:3i]; red=3'b100, yellow=3'b010, green=3'b001
- phase_idx  output  $clog2(NUM_PHASES)  phase currently or last served
- in_emerg  output  1  high while in EMERG state

Behaviour:
- Reset (async, active-high; clk and rst as in existing blocks):
  - state=ALLRED, timer=ALLRED_T-1, phase_idx=NUM_PHASES-1.
  - lights all 3'b100, in_emerg=0.
- States: ALLRED, GREEN, YELLOW, EMERG.
- lights, phase_idx and in_emerg are registered and change on the same edge as the state.
- Timer rule:
  - On entering a state, load duration-1.
  - Decrement only when tick_en=1.
  - Leave the state on the edge where tick_en=1 and timer==0.
  - With tick_en tied high, each state lasts exactly its duration in cycles.
- Exit from ALLRED at expiry:
  - Select the next phase round-robin: first index after phase_idx (wrapping NUM_PHASES-1 -> 0) with req set.
  - If no req bit is set, take phase_idx+1 (mod NUM_PHASES).
  - The current phase is eligible only after all others; a lone request on the current phase re-serves it.
  - Load phase_idx, go GREEN.
- GREEN: only lights[phase_idx] is 3'b001; all others 3'b100. At expiry, go YELLOW.
- YELLOW: lights[phase_idx]=3'b010. At expiry, go ALLRED.
- Emergency (emerg sampled every clk, independent of tick_en):
  - In GREEN: go YELLOW on the next edge, loading YELLOW_T-1.
  - In YELLOW: finish the interval normally.
  - Entering ALLRED with emerg=1, or emerg=1 while in ALLRED: go EMERG on the next edge.
  - EMERG: all red, in_emerg=1, timer held.
  - emerg=0 in EMERG: go ALLRED, load ALLRED_T-1, then normal selection from the held phase_idx.
- Simultaneous events:
  - emerg overrides timer expiry in GREEN and ALLRED.
  - req changes take effect only at ALLRED exit.
- Invariant: at most one phase is non-red in any cycle.
- Async reset mid-phase forces all red on assertion, without waiting for clk.

Optional Feature:
- Macro: TRAFFIC_GAP_EXTEND_EN.
- Defined:
  - In GREEN, if timer==0, tick_en=1 and req[phase_idx]=1, stay GREEN one more tick.
  - Total green is capped at MAX_GREEN_T ticks; a separate elapsed counter is reset on GREEN entry.
  - emerg still cuts green immediately.
- Undefined: green is always exactly GREEN_T ticks; req affects only phase selection.

Decomposition:
- Package traffic_pkg holds:
  - state enum {ALLRED, GREEN, YELLOW, EMERG}
  - lamp constants LAMP_RED/LAMP_YELLOW/LAMP_GREEN
  - a function replicating LAMP_RED across NUM_PHASES
- Sub-module traffic_rr_select: combinational round-robin next-phase picker.
  - Inputs: req, phase_idx.
  - Output: next index.
  - Parametrised by NUM_PHASES.

Test Plan:
- Free rotation. NUM_PHASES=4, GREEN_T=4, YELLOW_T=2, ALLRED_T=1, tick_en=1, req=0; release rst.
  -> All red 1 cycle, then phase 0 green 4 cycles, yellow 2, all red 1, then phases 1, 2, 3, 0.
  -> Period 28 cycles.
- Demand skip. req=4'b1000 held.
  -> Only phase 3 goes green, repeatedly, with ALLRED between yellows; phases 0-2 stay 3'b100.
- Timebase. tick_en pulsed every 5th cycle.
  -> Every state lasts 5x its tick count (phase 0 green 20 cycles).
  -> State unchanged on non-tick cycles.
- Emergency. emerg=1 at the 2nd cycle of phase 1 green.
  -> Yellow 2 cycles, then EMERG with all red and in_emerg=1 for as long as emerg is held.
  -> Drop emerg: 1 cycle all red, then phase 2 green.
- Async reset. Assert rst mid-yellow, between clock edges.
  -> lights all 3'b100 immediately; restart sequence identical to the free-rotation scenario.
- With TRAFFIC_GAP_EXTEND_EN, MAX_GREEN_T=6, req[0] held: phase 0 green 6 cycles.
  - Without the macro: 4 cycles.

Source files
------------

// File: rtl/traffic_pkg.sv
// ============================================================================
// Module  : traffic_pkg
// Brief   : Shared state encoding, lamp codes and lamp-vector helper for the
//           traffic phase controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  localparam int MAX_PHASES = 64;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    EMERG  = 2'd3
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Full-width result; callers keep the low 3*n bits.
  function automatic logic [3*MAX_PHASES-1:0] all_red_lamps(input int n);
    logic [3*MAX_PHASES-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      if (i < n) v[3*i +: 3] = LAMP_RED;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_rr_select.sv
// ============================================================================
// Module  : traffic_rr_select
// Brief   : Combinational round-robin picker of the next phase to serve.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_rr_select #(
  parameter int NUM_PHASES = 4,
  parameter int IW         = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] i_req,
  input  logic [IW-1:0]         i_phase_idx,
  output logic [IW-1:0]         o_next_idx
);

  int w_cand;

  // Scan offsets from farthest to nearest so the nearest requester wins;
  // offset NUM_PHASES is the current phase, giving it lowest priority.
  always_comb begin
    w_cand     = 0;
    o_next_idx = IW'((int'(i_phase_idx) + 1) % NUM_PHASES);
    for (int k = NUM_PHASES; k >= 1; k--) begin
      w_cand = (int'(i_phase_idx) + k) % NUM_PHASES;
      if (i_req[IW'(w_cand)]) o_next_idx = IW'(w_cand);
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_phase_controller.sv
// ============================================================================
// Module  : traffic_phase_controller
// Brief   : N-phase green/yellow/all-red sequencer with demand-driven
//           round-robin, timebase strobe and emergency preemption.
//           Optional green gap extension: define TRAFFIC_GAP_EXTEND_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int CNT_W       = 8,
  parameter int GREEN_T     = 7,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 2,
  parameter int MAX_GREEN_T = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_en,
  input  logic [NUM_PHASES-1:0]         req,
  input  logic                          emerg,
  output logic [3*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          in_emerg
);

  localparam int IW = $clog2(NUM_PHASES);
  localparam int LW = 3*NUM_PHASES;

  localparam logic [CNT_W-1:0] c_GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] c_YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] c_ALLRED_LD = CNT_W'(ALLRED_T - 1);

  localparam logic [3*MAX_PHASES-1:0] c_ALL_RED_FULL = all_red_lamps(NUM_PHASES);
  localparam logic [LW-1:0]           c_ALL_RED      = c_ALL_RED_FULL[LW-1:0];

  if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES || GREEN_T < 1 || YELLOW_T < 1 ||
      ALLRED_T < 1 || MAX_GREEN_T < GREEN_T || MAX_GREEN_T > 2**CNT_W) begin : g_param_check
    $error("traffic_phase_controller: illegal parameter combination");
  end

  function automatic logic [LW-1:0] lamp_at(input logic [IW-1:0] idx, input logic [2:0] code);
    logic [LW-1:0] v;
    v = c_ALL_RED;
    v[3*idx +: 3] = code;
    return v;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [IW-1:0]    r_phase;
  logic [LW-1:0]    r_lights;
  logic             r_in_emerg;
  logic [IW-1:0]    w_next_idx;
  logic             w_expire;

`ifdef TRAFFIC_GAP_EXTEND_EN
  localparam logic [CNT_W:0] c_MAX_G = (CNT_W+1)'(MAX_GREEN_T);
  logic [CNT_W-1:0] r_elapsed;
  logic             w_extend;
  // Stay green while the served approach still has demand and the ceiling allows it.
  assign w_extend = req[r_phase] && (({1'b0, r_elapsed} + 1'b1) < c_MAX_G);
`endif

  traffic_rr_select #(
    .NUM_PHASES (NUM_PHASES),
    .IW         (IW)
  ) u_rr (
    .i_req       (req),
    .i_phase_idx (r_phase),
    .o_next_idx  (w_next_idx)
  );

  assign w_expire = tick_en && (r_timer == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ALLRED;
      r_timer    <= c_ALLRED_LD;
      r_phase    <= IW'(NUM_PHASES - 1);
      r_lights   <= c_ALL_RED;
      r_in_emerg <= 1'b0;
`ifdef TRAFFIC_GAP_EXTEND_EN
      r_elapsed  <= '0;
`endif
    end else begin
      case (r_state)
        ALLRED: begin
          if (emerg) begin
            r_state    <= EMERG;
            r_in_emerg <= 1'b1;
          end else if (w_expire) begin
            r_state  <= GREEN;
            r_timer  <= c_GREEN_LD;
            r_phase  <= w_next_idx;
            r_lights <= lamp_at(w_next_idx, LAMP_GREEN);
`ifdef TRAFFIC_GAP_EXTEND_EN
            r_elapsed <= '0;
`endif
          end else if (tick_en) begin
            r_timer <= r_timer - 1'b1;
          end
        end
        GREEN: begin
          if (emerg) begin
            r_state  <= YELLOW;
            r_timer  <= c_YELLOW_LD;
            r_lights <= lamp_at(r_phase, LAMP_YELLOW);
`ifdef TRAFFIC_GAP_EXTEND_EN
          end else if (w_expire && w_extend) begin
            r_elapsed <= r_elapsed + 1'b1;
`endif
          end else if (w_expire) begin
            r_state  <= YELLOW;
            r_timer  <= c_YELLOW_LD;
            r_lights <= lamp_at(r_phase, LAMP_YELLOW);
          end else if (tick_en) begin
            r_timer <= r_timer - 1'b1;
`ifdef TRAFFIC_GAP_EXTEND_EN
            r_elapsed <= r_elapsed + 1'b1;
`endif
          end
        end
        YELLOW: begin
          if (w_expire) begin
            r_state  <= ALLRED;
            r_timer  <= c_ALLRED_LD;
            r_lights <= c_ALL_RED;
          end else if (tick_en) begin
            r_timer <= r_timer - 1'b1;
          end
        end
        EMERG: begin
          if (!emerg) begin
            r_state    <= ALLRED;
            r_timer    <= c_ALLRED_LD;
            r_in_emerg <= 1'b0;
          end
        end
        default: begin
          r_state    <= ALLRED;
          r_timer    <= c_ALLRED_LD;
          r_lights   <= c_ALL_RED;
          r_in_emerg <= 1'b0;
        end
      endcase
    end
  end

  assign lights    = r_lights;
  assign phase_idx = r_phase;
  assign in_emerg  = r_in_emerg;

endmodule

`default_nettype wire
